// File: rtl/pc_src_ctrl.sv
// Multi-cycle PC-source controller: IDLE -> FETCH (MEM_LAT cycles) -> DECODE -> EXEC.
// Drives the PC-source mux select and the PC/IR/link-register write enables.
module pc_src_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        ra_write,
  output logic        done,
  output logic        busy,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode, StExec} state_e;

  localparam logic [2:0] LastCnt = 3'(MEM_LAT - 1);

  localparam logic [5:0] OpJ   = 6'h02;
  localparam logic [5:0] OpJal = 6'h03;
  localparam logic [5:0] OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05;

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [5:0]  opcode_q;
  logic [15:0] count_q;
  logic        fetch_last;

  assign fetch_last  = (lat_q == LastCnt);
  assign instr_count = count_q;

  // Counter only advances inside FETCH, so it is already zero on every FETCH entry.
  assign lat_d = (state_q == StFetch && !fetch_last) ? lat_q + 3'd1 : 3'd0;

  always_comb begin
    state_d    = state_q;
    pc_src_sel = 3'b000;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    ra_write   = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        mem_read = 1'b1;
        if (fetch_last) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        state_d = StExec;
      end
      StExec: begin
        done = 1'b1;
        case (opcode_q)
          OpBeq: begin
            pc_src_sel = 3'b001;
            pc_write   = zero;
          end
          OpBne: begin
            pc_src_sel = 3'b001;
            pc_write   = ~zero;
          end
          OpJ: begin
            pc_src_sel = 3'b010;
            pc_write   = 1'b1;
          end
          OpJal: begin
            pc_src_sel = 3'b010;
            pc_write   = 1'b1;
            ra_write   = 1'b1;
          end
          default: ;
        endcase
        state_d = stop ? StIdle : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      lat_q    <= 3'd0;
      opcode_q <= 6'd0;
      count_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (state_q == StDecode) opcode_q <= opcode;
      if (state_q == StExec) count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Directed bench for pc_src_ctrl: opcode table plus reset, back-to-back and wrap sequences.
module tb_pc_src_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [5:0]  opcode;
  logic        zero;
  logic [2:0]  pc_src_sel;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        ra_write;
  logic        done;
  logic        busy;
  logic [15:0] instr_count;

  int unsigned total;
  int unsigned bad;
  logic [15:0] exp_cnt;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic [2:0] sel;
    logic       pcw;
    logic       ra;
  } vec_t;

  vec_t vecs[9];

  pc_src_ctrl #(.MEM_LAT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .opcode      (opcode),
    .zero        (zero),
    .pc_src_sel  (pc_src_sel),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .ra_write    (ra_write),
    .done        (done),
    .busy        (busy),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_ctrl"}, {26'd0, pc_src_sel, pc_write, ir_write, mem_read, ra_write, done}, 0);
  endtask

  // Called at a negedge with the FSM in IDLE; returns at the negedge after EXEC.
  task automatic run_instr(input logic [5:0] op, input logic z, input logic stp,
                           input logic [2:0] es, input logic ep, input logic er);
    start = 1'b1; stop = stp; opcode = op; zero = z;
    @(negedge clk);
    start = 1'b0;
    chk("fetch1_mem_read", {31'd0, mem_read}, 1);
    chk("fetch1_pc_ir_write", {30'd0, pc_write, ir_write}, 0);
    chk("fetch1_sel", {29'd0, pc_src_sel}, 0);
    @(negedge clk);
    chk("fetch2_mem_read", {31'd0, mem_read}, 1);
    chk("fetch2_pc_ir_write", {30'd0, pc_write, ir_write}, 32'd3);
    @(negedge clk);
    chk("decode_enables", {27'd0, pc_write, ir_write, mem_read, ra_write, done}, 0);
    chk("decode_busy", {31'd0, busy}, 1);
    @(negedge clk);
    opcode = ~op;  // EXEC must use the latched opcode
    #1;
    chk("exec_sel", {29'd0, pc_src_sel}, {29'd0, es});
    chk("exec_pc_write", {31'd0, pc_write}, {31'd0, ep});
    chk("exec_ra_write", {31'd0, ra_write}, {31'd0, er});
    chk("exec_done", {31'd0, done}, 1);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    chk("post_exec_count", {16'd0, instr_count}, {16'd0, exp_cnt});
    chk("post_exec_busy", {31'd0, busy}, stp ? 32'd0 : 32'd1);
    chk("post_exec_done", {31'd0, done}, 0);
  endtask

  initial begin
    total = 0; bad = 0; exp_cnt = 16'd0;
    vecs[0] = '{op: 6'h00, z: 1'b0, sel: 3'b000, pcw: 1'b0, ra: 1'b0};
    vecs[1] = '{op: 6'h04, z: 1'b1, sel: 3'b001, pcw: 1'b1, ra: 1'b0};
    vecs[2] = '{op: 6'h04, z: 1'b0, sel: 3'b001, pcw: 1'b0, ra: 1'b0};
    vecs[3] = '{op: 6'h05, z: 1'b0, sel: 3'b001, pcw: 1'b1, ra: 1'b0};
    vecs[4] = '{op: 6'h05, z: 1'b1, sel: 3'b001, pcw: 1'b0, ra: 1'b0};
    vecs[5] = '{op: 6'h02, z: 1'b0, sel: 3'b010, pcw: 1'b1, ra: 1'b0};
    vecs[6] = '{op: 6'h03, z: 1'b1, sel: 3'b010, pcw: 1'b1, ra: 1'b1};
    vecs[7] = '{op: 6'h3f, z: 1'b1, sel: 3'b000, pcw: 1'b0, ra: 1'b0};
    vecs[8] = '{op: 6'h06, z: 1'b0, sel: 3'b000, pcw: 1'b0, ra: 1'b0};

    // Reset has priority over start and stop.
    reset = 1'b1; start = 1'b1; stop = 1'b1; opcode = 6'h04; zero = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_count", {16'd0, instr_count}, 0);
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk_idle("idle_no_start");

    // Opcode table; start and stop both high in IDLE run one instruction then return.
    for (int i = 0; i < 9; i++) begin
      run_instr(vecs[i].op, vecs[i].z, 1'b1, vecs[i].sel, vecs[i].pcw, vecs[i].ra);
      chk_idle("after_vec");
    end

    // Reset during the second FETCH cycle.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 16'd0;
    chk_idle("rst_fetch");
    chk("rst_fetch_count", {16'd0, instr_count}, 0);
    @(negedge clk);
    chk_idle("rst_fetch_hold");

    // Back-to-back: stop low at EXEC continues into FETCH.
    run_instr(6'h02, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0);
    chk("b2b_fetch_mem_read", {31'd0, mem_read}, 1);
    stop = 1'b1; opcode = 6'h05; zero = 1'b0;
    @(negedge clk);
    chk("b2b_fetch2_ir_write", {31'd0, ir_write}, 1);
    @(negedge clk);
    @(negedge clk);
    opcode = 6'h00;
    #1;
    chk("b2b_exec_sel", {29'd0, pc_src_sel}, 32'd1);
    chk("b2b_exec_pc_write", {31'd0, pc_write}, 1);
    zero = 1'b1;  // pc_write follows zero combinationally in EXEC
    #1;
    chk("b2b_exec_zero_comb", {31'd0, pc_write}, 0);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    chk_idle("b2b_end");
    chk("b2b_count", {16'd0, instr_count}, {16'd0, exp_cnt});

    // Reset during EXEC aborts the retirement.
    start = 1'b1; stop = 1'b0; opcode = 6'h03;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_exec_pre_done", {31'd0, done}, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; stop = 1'b1;
    exp_cnt = 16'd0;
    chk_idle("rst_exec");
    chk("rst_exec_count", {16'd0, instr_count}, 0);
    @(negedge clk);
    chk_idle("rst_exec_hold");

    // Counter wrap: preload 0xFFFF while idle, then retire one more.
    force dut.count_q = 16'hffff;
    #1;
    release dut.count_q;
    @(negedge clk);
    chk("wrap_preload", {16'd0, instr_count}, 32'hffff);
    exp_cnt = 16'hffff;
    run_instr(6'h00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("wrap_zero", {16'd0, instr_count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_src_ctrl.md
PC_SRC_CTRL -- requirements
Module: pc_src_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles (legal 1..7).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  level; leaves IDLE and begins fetching.
REQ-005 stop  input  1  level; sampled at end of EXEC, returns to IDLE.
REQ-006 opcode  input  6  instruction opcode, valid in the DECODE cycle.
REQ-007 zero  input  1  ALU zero flag, valid in the EXEC cycle.
REQ-008 pc_src_sel  output  3  selector of the 3-input 32-bit PC-source mux: 000 = PC+4, 001 = branch target, 010 = jump target.
REQ-009 pc_write  output  1  PC load enable.
REQ-010 ir_write  output  1  instruction register load enable.
REQ-011 mem_read  output  1  instruction memory read request.
REQ-012 ra_write  output  1  link-register write enable (JAL).
REQ-013 done  output  1  one-cycle pulse per retired instruction.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 instr_count  output  16  retired-instruction counter.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, FETCH, DECODE, EXEC.
REQ-017 IDLE: all control outputs 0, pc_src_sel 000; the FSM goes to FETCH when start=1, else stays.
REQ-018 FETCH: mem_read=1 and pc_src_sel=000 for exactly MEM_LAT cycles, counted by an internal counter cleared on FETCH entry.
REQ-019 The last FETCH cycle SHALL assert pc_write=1 and ir_write=1 for exactly one cycle; the FSM then goes to DECODE.
REQ-020 DECODE: one cycle, all enables 0; opcode latched into an internal register; the FSM goes to EXEC.
REQ-021 EXEC decodes the latched opcode in one cycle:
- 0x04 (BEQ): pc_src_sel=001 and pc_write=zero.
- 0x05 (BNE): pc_src_sel=001 and pc_write=~zero.
- 0x02 (J): pc_src_sel=010 and pc_write=1.
- 0x03 (JAL): pc_src_sel=010, pc_write=1 and ra_write=1.
- Any other opcode: pc_src_sel=000 and pc_write=0.
REQ-022 In EXEC, pc_write SHALL depend combinationally on zero in the same cycle; all other outputs SHALL be functions of state and latched opcode only.
REQ-023 pc_src_sel SHALL never take a value other than 000, 001 or 010.
REQ-024 EXEC SHALL pulse done=1 and increment instr_count by 1, wrapping from 0xFFFF to 0x0000.
REQ-025 Leaving EXEC: the FSM goes to IDLE if stop=1, else to FETCH; start is ignored outside IDLE.
REQ-026 pc_write SHALL be asserted at most once per state visit, and at most twice per instruction (fetch and exec).
REQ-027 When start and stop are both 1 in IDLE, the FSM SHALL go to FETCH, and the instruction SHALL complete before stop is honored.

Reset
REQ-028 When reset=1 at a clock edge, the FSM SHALL enter IDLE, clear the latency counter, opcode register and instr_count, and drive all outputs to 0 on the next cycle, regardless of state.
REQ-029 Reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction with no further pc_write, ir_write or done.
REQ-030 Reset SHALL take priority over start and stop.

Verification
REQ-031 Reset, then start=1 with MEM_LAT=2 and opcode 0x00 -> mem_read high for cycles 1-2; pc_write and ir_write in cycle 2; done in cycle 4; instr_count=1.
REQ-032 BEQ with zero=1 -> EXEC shows pc_src_sel=001, pc_write=1; with zero=0 -> pc_write=0, done=1.
REQ-033 BNE with zero=0 -> pc_write=1 with sel 001; JAL -> sel 010, pc_write=1, ra_write=1 in the same cycle.
REQ-034 Reset asserted during the second FETCH cycle -> next cycle IDLE, all outputs 0, instr_count=0, no ir_write.
REQ-035 Preload instr_count=0xFFFF by running 65535 instructions, then one more -> instr_count=0x0000.
REQ-036 stop=1 held during EXEC -> IDLE next cycle with busy=0; start and stop both high in IDLE -> one full instruction, then IDLE.
